seq_borrow_skip_subtractor: RTL and testbench



---
 rtl/seq_borrow_skip_subtractor_if.sv | 26 ++
 rtl/seq_borrow_skip_subtractor.sv | 115 +++++++++++
 tb/tb_seq_borrow_skip_subtractor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_borrow_skip_subtractor_if.sv
// Operand/result handshake bundle for the borrow-skip subtractor.
// slave = subtractor side, master = producer/consumer side.
interface seq_borrow_skip_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, overflow
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, overflow
    );
endinterface

// File: rtl/seq_borrow_skip_subtractor.sv
// Multi-cycle borrow-skip subtractor: diff = a - b - bin, one 4-bit block per clock.
// Optional macro SKIP_STATS_EN adds skip_cnt, the number of blocks that took the skip path.
module seq_borrow_skip_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    seq_borrow_skip_subtractor_if.slave bus
`ifdef SKIP_STATS_EN
    ,
    output logic [$clog2(WIDTH/4+1)-1:0] skip_cnt
`endif
);
    localparam int NBLK = WIDTH / 4;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             brw;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             valid_r;

    logic [3:0]       ab;
    logic [3:0]       bb;
    logic [3:0]       d;
    logic             br;
    logic             p;
    logic             blk_bout;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = valid_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.overflow  = ovf_r;

    // Current block: rippled difference bits plus skip-path borrow-out
    always_comb begin
        ab = a_r[idx*4 +: 4];
        bb = b_r[idx*4 +: 4];
        br = brw;
        d  = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = ab[k] ^ bb[k] ^ br;
            br   = (~ab[k] & bb[k]) | (~(ab[k] ^ bb[k]) & br);
        end
        p        = &(~(ab ^ bb));
        blk_bout = p ? brw : br;
    end

    // Control FSM and all registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            brw     <= 1'b0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
`ifdef SKIP_STATS_EN
            skip_cnt <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        brw    <= bus.bin;
                        diff_r <= '0;
                        idx    <= '0;
`ifdef SKIP_STATS_EN
                        skip_cnt <= '0;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
                    diff_r[idx*4 +: 4] <= d;
                    brw <= blk_bout;
                    idx <= idx + 1'b1;
`ifdef SKIP_STATS_EN
                    skip_cnt <= skip_cnt + {{($bits(skip_cnt)-1){1'b0}}, p};
`endif
                    if (idx == IW'(NBLK - 1)) begin
                        bout_r  <= blk_bout;
                        ovf_r   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                   (d[3] != a_r[WIDTH-1]);
                        valid_r <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_borrow_skip_subtractor.sv
// Randomised self-checking bench for seq_borrow_skip_subtractor (WIDTH=16).
// Reference results come from plain integer arithmetic.
module tb_seq_borrow_skip_subtractor;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_borrow_skip_subtractor_if #(.WIDTH(W)) bus ();

`ifdef SKIP_STATS_EN
    logic [2:0] skip_cnt;
`endif

    seq_borrow_skip_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef SKIP_STATS_EN
        ,
        .skip_cnt (skip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic bin, output logic [15:0] d,
                                  output logic bo, output logic ov,
                                  output int sk);
        int r;
        int s;
        r  = int'(a) - int'(b) - int'(bin);
        d  = r[15:0];
        bo = (r < 0);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov = (s < -32768) || (s > 32767);
        sk = 0;
        for (int i = 0; i < 4; i++)
            if (a[i*4 +: 4] == b[i*4 +: 4]) sk++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input int hold);
        logic [15:0] ed;
        logic        eb;
        logic        eo;
        int          es;
        int          lat;
        int          waitc;
        model(a, b, bin, ed, eb, eo, es);
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("diff", 32'(bus.diff), 32'(ed));
        check("bout", 32'(bus.bout), 32'(eb));
        check("overflow", 32'(bus.overflow), 32'(eo));
`ifdef SKIP_STATS_EN
        check("skip_cnt", 32'(skip_cnt), 32'(es));
`endif
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.bin      = 1'($urandom);
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_diff", 32'(bus.diff), 32'(ed));
            check("hold_bout", 32'(bus.bout), 32'(eb));
            check("hold_ovf", 32'(bus.overflow), 32'(eo));
`ifdef SKIP_STATS_EN
            check("hold_skip", 32'(skip_cnt), 32'(es));
`endif
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
`ifdef SKIP_STATS_EN
        check("rst_skip", 32'(skip_cnt), 32'd0);
`endif
        rst = 1'b0;

        do_op(16'h1234, 16'h0234, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 0);
        do_op(16'hABCD, 16'hABCD, 1'b1, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b1, 3);

        bus.a        = 16'h1234;
        bus.b        = 16'h0234;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        do_op(16'h0005, 16'h0003, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb[7:0] = ra[7:0];
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
